// File: rtl/energy_accept_ctrl.sv
// Single-spin-flip accept/reject controller wrapped around the sigma^T*J*sigma energy engine.
// Proposes LFSR-chosen flips, keeps strictly-lower energies and tracks the best state of the run.
module energy_accept_ctrl #(
  parameter int          VECTOR_SIZE  = 256,
  parameter int          ENERGY_WIDTH = 21,
  parameter int          ITER_WIDTH   = 16,
  parameter int          TIMEOUT      = 1024,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cfg_start,
  input  logic [VECTOR_SIZE-1:0]         cfg_sigma,
  input  logic signed [ENERGY_WIDTH-1:0] cfg_energy,
  input  logic [ITER_WIDTH-1:0]          cfg_num_iters,
  input  logic signed [ENERGY_WIDTH-1:0] energy_in,
  input  logic                           energy_valid,
  output logic                           mm_start,
  output logic [VECTOR_SIZE-1:0]         sigma_out,
  output logic signed [ENERGY_WIDTH-1:0] energy_prev_out,
  output logic [VECTOR_SIZE-1:0]         best_sigma,
  output logic signed [ENERGY_WIDTH-1:0] best_energy,
  output logic [ITER_WIDTH-1:0]          iter_count,
  output logic [ITER_WIDTH-1:0]          accept_count,
  output logic                           busy,
  output logic                           done,
  output logic                           error
);

  localparam int IDX_W = $clog2(VECTOR_SIZE);
  localparam int CTR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_DECIDE, S_DONE} state_e;

  state_e                         state_q, state_d;
  logic [VECTOR_SIZE-1:0]         sigma_cur_q, sigma_cur_d;
  logic [VECTOR_SIZE-1:0]         cand_q, cand_d;
  logic [VECTOR_SIZE-1:0]         best_sigma_q, best_sigma_d;
  logic signed [ENERGY_WIDTH-1:0] e_cur_q, e_cur_d;
  logic signed [ENERGY_WIDTH-1:0] e_in_q, e_in_d;
  logic signed [ENERGY_WIDTH-1:0] best_e_q, best_e_d;
  logic [ITER_WIDTH-1:0]          iter_q, iter_d;
  logic [ITER_WIDTH-1:0]          acc_q, acc_d;
  logic [ITER_WIDTH-1:0]          num_iters_q, num_iters_d;
  logic [15:0]                    lfsr_q, lfsr_d;
  logic [CTR_W-1:0]               ctr_q, ctr_d;
  logic                           error_q, error_d;
  logic                           accept;
  logic [VECTOR_SIZE-1:0]         sigma_next;

  // Fibonacci x^16+x^14+x^13+x^11+1, shifting left with feedback into bit 0.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic logic [VECTOR_SIZE-1:0] flip_bit(input logic [VECTOR_SIZE-1:0] v,
                                                      input logic [IDX_W-1:0]       idx);
    logic [VECTOR_SIZE-1:0] r;
    r      = v;
    r[idx] = ~v[idx];
    return r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      sigma_cur_q  <= '0;
      cand_q       <= '0;
      best_sigma_q <= '0;
      e_cur_q      <= '0;
      e_in_q       <= '0;
      best_e_q     <= '0;
      iter_q       <= '0;
      acc_q        <= '0;
      num_iters_q  <= '0;
      lfsr_q       <= LFSR_SEED;
      ctr_q        <= '0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      sigma_cur_q  <= sigma_cur_d;
      cand_q       <= cand_d;
      best_sigma_q <= best_sigma_d;
      e_cur_q      <= e_cur_d;
      e_in_q       <= e_in_d;
      best_e_q     <= best_e_d;
      iter_q       <= iter_d;
      acc_q        <= acc_d;
      num_iters_q  <= num_iters_d;
      lfsr_q       <= lfsr_d;
      ctr_q        <= ctr_d;
      error_q      <= error_d;
    end
  end

  // NOTE: every _d gets its hold value first so no path through the case can infer a latch.
  always_comb begin
    state_d      = state_q;
    sigma_cur_d  = sigma_cur_q;
    cand_d       = cand_q;
    best_sigma_d = best_sigma_q;
    e_cur_d      = e_cur_q;
    e_in_d       = e_in_q;
    best_e_d     = best_e_q;
    iter_d       = iter_q;
    acc_d        = acc_q;
    num_iters_d  = num_iters_q;
    lfsr_d       = lfsr_q;
    ctr_d        = ctr_q;
    error_d      = error_q;
    accept       = 1'b0;
    sigma_next   = sigma_cur_q;

    unique case (state_q)
      S_IDLE: begin
        if (cfg_start) begin
          sigma_cur_d  = cfg_sigma;
          e_cur_d      = cfg_energy;
          best_sigma_d = cfg_sigma;
          best_e_d     = cfg_energy;
          iter_d       = '0;
          acc_d        = '0;
          error_d      = 1'b0;
          num_iters_d  = cfg_num_iters;
          lfsr_d       = LFSR_SEED;
          if (cfg_num_iters == '0) begin
            state_d = S_DONE;
          end else begin
            cand_d  = flip_bit(cfg_sigma, LFSR_SEED[IDX_W-1:0]);
            lfsr_d  = lfsr_step(LFSR_SEED);
            state_d = S_LAUNCH;
          end
        end
      end
      S_LAUNCH: begin
        ctr_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (energy_valid) begin
          e_in_d  = energy_in;
          state_d = S_DECIDE;
        end else if (ctr_q == CTR_W'(TIMEOUT - 1)) begin
          error_d = 1'b1;
          state_d = S_DONE;
        end else begin
          ctr_d = ctr_q + 1'b1;
        end
      end
      S_DECIDE: begin
        accept = (e_in_q < e_cur_q);
        if (accept) begin
          sigma_next  = cand_q;
          sigma_cur_d = cand_q;
          e_cur_d     = e_in_q;
          acc_d       = acc_q + 1'b1;
          if (e_in_q < best_e_q) begin
            best_sigma_d = cand_q;
            best_e_d     = e_in_q;
          end
        end
        iter_d = iter_q + 1'b1;
        if (iter_d == num_iters_q) begin
          state_d = S_DONE;
        end else begin
          // Next candidate is built from the post-decision vector.
          cand_d  = flip_bit(sigma_next, lfsr_q[IDX_W-1:0]);
          lfsr_d  = lfsr_step(lfsr_q);
          state_d = S_LAUNCH;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign mm_start        = (state_q == S_LAUNCH);
  assign busy            = (state_q != S_IDLE);
  assign done            = (state_q == S_DONE);
  assign error           = error_q;
  assign sigma_out       = cand_q;
  assign energy_prev_out = e_cur_q;
  assign best_sigma      = best_sigma_q;
  assign best_energy     = best_e_q;
  assign iter_count      = iter_q;
  assign accept_count    = acc_q;

endmodule

// File: tb/tb_energy_accept_ctrl.sv
// Scoreboard bench for energy_accept_ctrl: stimulus queues expected launches and run results,
// monitors pop and compare whenever the DUT pulses mm_start or done.
module tb_energy_accept_ctrl;

  localparam int VS = 256;
  localparam int EW = 21;
  localparam int IW = 16;
  localparam int TO = 8;

  typedef struct {
    logic [VS-1:0]        sigma;
    logic signed [EW-1:0] eprev;
  } launch_t;

  typedef struct {
    logic [IW-1:0]        iters;
    logic [IW-1:0]        acc;
    logic signed [EW-1:0] best_e;
    logic [VS-1:0]        best_s;
    logic signed [EW-1:0] e_cur;
    logic                 err;
  } done_t;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 cfg_start = 1'b0;
  logic [VS-1:0]        cfg_sigma = '0;
  logic signed [EW-1:0] cfg_energy = '0;
  logic [IW-1:0]        cfg_num_iters = '0;
  logic signed [EW-1:0] energy_in = '0;
  logic                 energy_valid = 1'b0;
  logic                 mm_start;
  logic [VS-1:0]        sigma_out;
  logic signed [EW-1:0] energy_prev_out;
  logic [VS-1:0]        best_sigma;
  logic signed [EW-1:0] best_energy;
  logic [IW-1:0]        iter_count;
  logic [IW-1:0]        accept_count;
  logic                 busy;
  logic                 done;
  logic                 error;

  int n_checks = 0;
  int n_fail   = 0;

  launch_t              launch_q[$];
  done_t                done_q[$];
  logic signed [EW-1:0] resp_q[$];

  int lat_min    = 1;
  int lat_max    = 1;
  bit silent     = 1'b0;
  bit stray_mode = 1'b0;

  energy_accept_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .cfg_start(cfg_start), .cfg_sigma(cfg_sigma), .cfg_energy(cfg_energy),
    .cfg_num_iters(cfg_num_iters), .energy_in(energy_in), .energy_valid(energy_valid),
    .mm_start(mm_start), .sigma_out(sigma_out), .energy_prev_out(energy_prev_out),
    .best_sigma(best_sigma), .best_energy(best_energy), .iter_count(iter_count),
    .accept_count(accept_count), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [VS-1:0] flip(input logic [VS-1:0] v, input logic [7:0] idx);
    logic [VS-1:0] r;
    r      = v;
    r[idx] = ~r[idx];
    return r;
  endfunction

  task automatic push_launch(input logic [VS-1:0] s, input logic signed [EW-1:0] e);
    launch_t l;
    l.sigma = s;
    l.eprev = e;
    launch_q.push_back(l);
  endtask

  task automatic push_done(input int iters, input int acc, input logic signed [EW-1:0] best_e,
                           input logic [VS-1:0] best_s, input logic signed [EW-1:0] e_cur,
                           input logic err);
    done_t d;
    d.iters  = IW'(iters);
    d.acc    = IW'(acc);
    d.best_e = best_e;
    d.best_s = best_s;
    d.e_cur  = e_cur;
    d.err    = err;
    done_q.push_back(d);
  endtask

  // Called just after a negedge; returns at the negedge after the start edge.
  task automatic start_job(input logic [VS-1:0] s, input logic signed [EW-1:0] e, input int n);
    cfg_sigma     = s;
    cfg_energy    = e;
    cfg_num_iters = IW'(n);
    cfg_start     = 1'b1;
    @(negedge clk);
    cfg_start     = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int k;
    k = 0;
    while (!done && k < budget) begin
      @(negedge clk);
      k++;
    end
    check({name, "_done_seen"}, done, 1'b1);
    @(negedge clk);
  endtask

  // Golden model for a random run: LFSR-picked flips, strict-less acceptance, best tracking.
  task automatic model_job(input logic [VS-1:0] s0, input logic signed [EW-1:0] e0, input int n);
    logic [VS-1:0]        s, bs, c;
    logic signed [EW-1:0] e, be, r;
    logic [15:0]          l;
    int                   acc, d;
    s = s0; bs = s0; e = e0; be = e0; l = 16'hACE1; acc = 0;
    for (int k = 0; k < n; k++) begin
      c = flip(s, l[7:0]);
      l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
      push_launch(c, e);
      d = int'($urandom_range(40)) - 20;
      r = e + EW'(d);
      resp_q.push_back(r);
      if (r < e) begin
        s = c;
        e = r;
        acc++;
        if (r < be) begin
          be = r;
          bs = c;
        end
      end
    end
    push_done(n, acc, be, bs, e, 1'b0);
  endtask

  // Engine model: answers each mm_start after a random latency; optional stray valid in DECIDE.
  initial begin
    int  cnt;
    bit  stray_next;
    cnt = -1;
    stray_next = 1'b0;
    forever begin
      @(negedge clk);
      energy_valid = 1'b0;
      if (stray_next) begin
        energy_valid = 1'b1;
        energy_in    = -EW'(12345);
        stray_next   = 1'b0;
      end
      if (cnt > 0) cnt--;
      if (cnt == 0) begin
        check("resp_available", resp_q.size() > 0, 1'b1);
        if (resp_q.size() > 0) begin
          energy_in    = resp_q.pop_front();
          energy_valid = 1'b1;
          stray_next   = stray_mode;
        end
        cnt = -1;
      end
      if (mm_start && !silent) cnt = $urandom_range(lat_max, lat_min);
    end
  end

  initial begin
    launch_t ml;
    forever begin
      @(negedge clk);
      if (mm_start) begin
        check("launch_expected", launch_q.size() > 0, 1'b1);
        if (launch_q.size() > 0) begin
          ml = launch_q.pop_front();
          check("sigma_out", sigma_out, ml.sigma);
          check("energy_prev_out", energy_prev_out, ml.eprev);
        end
      end
    end
  end

  initial begin
    done_t md;
    forever begin
      @(negedge clk);
      if (done) begin
        check("done_expected", done_q.size() > 0, 1'b1);
        if (done_q.size() > 0) begin
          md = done_q.pop_front();
          check("iter_count", iter_count, md.iters);
          check("accept_count", accept_count, md.acc);
          check("best_energy", best_energy, md.best_e);
          check("best_sigma", best_sigma, md.best_s);
          check("e_cur", energy_prev_out, md.e_cur);
          check("error", error, md.err);
          check("busy_in_done", busy, 1'b1);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [VS-1:0]        s2, s3, s4, s6, l1, l3;
    logic signed [EW-1:0] exp_e;
    int                   k;

    // Power-on reset state
    repeat (2) @(negedge clk);
    check("rst_mm_start", mm_start, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_iter_count", iter_count, '0);
    check("rst_accept_count", accept_count, '0);
    check("rst_sigma_out", sigma_out, '0);
    check("rst_best_sigma", best_sigma, '0);
    check("rst_best_energy", best_energy, '0);
    check("rst_energy_prev", energy_prev_out, '0);
    rst = 1'b0;
    @(negedge clk);

    // num_iters = 0: immediate done, best = cfg
    s2 = {4{64'h0F0F_3C3C_A5A5_5A5A}};
    push_done(0, 0, -EW'(5), s2, -EW'(5), 1'b0);
    start_job(s2, -EW'(5), 0);
    check("t2_done_after_start", done, 1'b1);
    wait_done("t2", 10);

    // Accept / reject sequence 100 -> 90 (acc), 95 (rej), 80 (acc); LFSR idx E1, C3, 87
    lat_min = 1; lat_max = 3;
    s3 = {8{32'h1234_5678}};
    l1 = flip(s3, 8'hE1);
    l3 = flip(l1, 8'h87);
    push_launch(l1, EW'(100));
    push_launch(flip(l1, 8'hC3), EW'(90));
    push_launch(l3, EW'(90));
    resp_q.push_back(EW'(90));
    resp_q.push_back(EW'(95));
    resp_q.push_back(EW'(80));
    push_done(3, 2, EW'(80), l3, EW'(80), 1'b0);
    start_job(s3, EW'(100), 3);
    wait_done("t3", 100);
    check("t3_accept_count_hand", accept_count, IW'(2));
    exp_e = 80;
    check("t3_best_energy_hand", best_energy, exp_e);

    // Tie is rejected
    s4 = ~s3;
    push_launch(flip(s4, 8'hE1), -EW'(7));
    resp_q.push_back(-EW'(7));
    push_done(1, 0, -EW'(7), s4, -EW'(7), 1'b0);
    start_job(s4, -EW'(7), 1);
    wait_done("t4", 50);
    check("t4_best_sigma_hand", best_sigma, s4);

    // Timeout: engine never answers, TIMEOUT WAIT cycles then DONE with error
    silent = 1'b1;
    push_launch(flip(s3, 8'hE1), EW'(33));
    push_done(0, 0, EW'(33), s3, EW'(33), 1'b1);
    start_job(s3, EW'(33), 2);
    k = 0;
    while (!done && k < 30) begin
      @(negedge clk);
      k++;
    end
    check("t5_timeout_latency", k, TO + 1);
    @(negedge clk);
    check("t5_busy_after_done", busy, 1'b0);
    check("t5_error_sticky", error, 1'b1);
    silent = 1'b0;

    // Reset mid-WAIT aborts; later engine answer ignored
    lat_min = 4; lat_max = 4;
    push_launch(flip(s2, 8'hE1), EW'(500));
    resp_q.push_back(-EW'(900));
    start_job(s2, EW'(500), 3);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t1_mm_start", mm_start, 1'b0);
    check("t1_busy", busy, 1'b0);
    check("t1_done", done, 1'b0);
    check("t1_iter_count", iter_count, '0);
    check("t1_sigma_out", sigma_out, '0);
    check("t1_best_sigma", best_sigma, '0);
    check("t1_best_energy", best_energy, '0);
    check("t1_energy_prev", energy_prev_out, '0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("t1_busy_after_stray", busy, 1'b0);
    check("t1_iter_after_stray", iter_count, '0);
    check("t1_accept_after_stray", accept_count, '0);

    // Long random run vs golden model, with stray valids in DECIDE and a cfg_start while busy
    lat_min = 1; lat_max = 4;
    stray_mode = 1'b1;
    for (int w = 0; w < VS / 32; w++) s6[w*32 +: 32] = $urandom;
    model_job(s6, EW'(1000), 1000);
    start_job(s6, EW'(1000), 1000);
    repeat (5) @(negedge clk);
    cfg_sigma     = ~s6;
    cfg_energy    = -EW'(4000);
    cfg_num_iters = IW'(1);
    cfg_start     = 1'b1;
    @(negedge clk);
    cfg_start     = 1'b0;
    wait_done("t6", 20000);
    stray_mode = 1'b0;
    repeat (3) @(negedge clk);

    check("launch_q_drained", launch_q.size(), 0);
    check("done_q_drained", done_q.size(), 0);
    check("resp_q_drained", resp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
